// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and default constants for the PC fetch controller slice.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD,
    ERR
  } state_t;

  localparam int unsigned DEF_AW       = 8;
  localparam int unsigned DEF_DW       = 8;
  localparam int unsigned DEF_STEP     = 4;
  localparam int unsigned DEF_RESET_PC = 0;
  localparam int unsigned DEF_MAX_WAIT = 15;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request port and decoder-side word handshake.
interface pc_fetch_ctrl_if
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
);

  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          inst_valid;
  logic [DW-1:0] inst_data;
  logic [AW-1:0] inst_pc;
  logic          inst_ready;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/pc_fetch_ctrl_wdog.sv
// Saturating wait counter; expired flags the cycle in which the count reaches MAX_WAIT.
module pc_ctrl_wdog #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != CW'(MAX_WAIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = en && (cnt >= CW'(MAX_WAIT - 1));

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter fetch sequencer: one outstanding memory read, one buffered word.
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned STEP     = DEF_STEP,
  parameter int unsigned RESET_PC = DEF_RESET_PC,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  pc_fetch_ctrl_if.master bus,
  output logic [AW-1:0] pc_out,
  output logic          timeout_err
);

  state_t        state, state_n;
  logic [AW-1:0] pc_n, addr_n, ipc_n;
  logic [DW-1:0] data_n;
  logic          req_n, valid_n, err_n;
  logic          squash, squash_n;
  logic          wdog_expired;

  pc_ctrl_wdog #(.MAX_WAIT(MAX_WAIT)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     ((state != WAIT) || bus.mem_ack),
    .en      ((state == WAIT) && !bus.mem_ack),
    .expired (wdog_expired)
  );

  always_comb begin
    state_n  = state;
    pc_n     = pc_out;
    req_n    = bus.mem_req;
    addr_n   = bus.mem_addr;
    valid_n  = bus.inst_valid;
    data_n   = bus.inst_data;
    ipc_n    = bus.inst_pc;
    err_n    = timeout_err;
    squash_n = squash;

    if (redirect_valid) begin
      pc_n = redirect_pc;
      if (state == WAIT && !bus.mem_ack) begin
        // Request stays in flight; its data is dropped when the ack arrives.
        squash_n = 1'b1;
      end else if (state == ERR) begin
        err_n   = 1'b0;
        state_n = IDLE;
      end else begin
        squash_n = 1'b0;
        valid_n  = 1'b0;
        req_n    = run;
        if (run) addr_n = redirect_pc;
        state_n  = run ? WAIT : IDLE;
      end
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            req_n   = 1'b1;
            addr_n  = pc_out;
            state_n = WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_ack) begin
            if (squash) begin
              squash_n = 1'b0;
              req_n    = run;
              if (run) addr_n = pc_out;
              state_n  = run ? WAIT : IDLE;
            end else begin
              data_n  = bus.mem_rdata;
              ipc_n   = bus.mem_addr;
              valid_n = 1'b1;
              pc_n    = pc_out + AW'(STEP);
              req_n   = 1'b0;
              state_n = HOLD;
            end
          end else if (wdog_expired) begin
            req_n    = 1'b0;
            err_n    = 1'b1;
            squash_n = 1'b0;
            state_n  = ERR;
          end
        end
        HOLD: begin
          if (!bus.inst_valid || bus.inst_ready) begin
            valid_n = 1'b0;
            req_n   = run;
            if (run) addr_n = pc_out;
            state_n = run ? WAIT : IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc_out         <= AW'(RESET_PC);
      bus.mem_req    <= 1'b0;
      bus.mem_addr   <= AW'(RESET_PC);
      bus.inst_valid <= 1'b0;
      bus.inst_data  <= '0;
      bus.inst_pc    <= '0;
      timeout_err    <= 1'b0;
      squash         <= 1'b0;
    end else begin
      state          <= state_n;
      pc_out         <= pc_n;
      bus.mem_req    <= req_n;
      bus.mem_addr   <= addr_n;
      bus.inst_valid <= valid_n;
      bus.inst_data  <= data_n;
      bus.inst_pc    <= ipc_n;
      timeout_err    <= err_n;
      squash         <= squash_n;
    end
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Sequences the program counter through instruction fetch: issues a req/ack read to instruction memory at the current PC.
- Buffers one fetched word toward the decoder with a valid/ready handshake.
- Applies redirects (jumps/branches) and advances PC by a fixed step.
- Sits between the PC register and the instruction memory port; watchdog flags a memory that never acknowledges.

Parameters:
- AW, 8, PC/address width
- DW, 8, instruction word width
- STEP, 4, PC increment per fetched word
- RESET_PC, 0, PC value after reset
- MAX_WAIT, 15, max cycles mem_req may stay unacknowledged before error

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  fetch enable; low = finish current transfer, then idle
- redirect_valid  in  1  load redirect_pc as next fetch address (one-cycle pulse)
- redirect_pc  in  AW  redirect target
- mem_req  out  1  fetch request, held until mem_ack
- mem_addr  out  AW  fetch address, stable while mem_req=1
- mem_ack  in  1  memory accepts request; mem_rdata valid this cycle
- mem_rdata  in  DW  fetched word
- inst_valid  out  1  inst_data/inst_pc hold an unconsumed word
- inst_data  out  DW  buffered instruction
- inst_pc  out  AW  address inst_data was fetched from
- inst_ready  in  1  consumer accepts word when inst_valid=1
- pc_out  out  AW  next fetch address (architectural PC)
- timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset (async assert, sync deassert by clk edge):
  - state=IDLE, pc_out=RESET_PC
  - mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0
  - timeout_err=0, squash=0, wait counter=0
- All outputs are registered.
- States: IDLE, WAIT, HOLD, ERR.
- IDLE:
  - run=1 -> mem_req=1, mem_addr=pc_out next cycle, go WAIT.
  - Latency: run sampled at edge N, mem_req visible after N.
- WAIT:
  - mem_req stays 1 and mem_addr stays frozen until mem_ack.
  - On mem_ack, no squash: inst_data<=mem_rdata, inst_pc<=mem_addr, inst_valid<=1, pc_out<=pc_out+STEP (mod 2^AW, wraps silently), mem_req<=0, go HOLD.
  - Minimum ack-to-inst_valid latency is 1 cycle.
- HOLD:
  - On inst_valid&inst_ready: inst_valid<=0.
  - If run=1: mem_req<=1 with the new pc_out, go WAIT (back-to-back fetches, 1 bubble cycle). If run=0: go IDLE.
- Watchdog:
  - Counter increments each WAIT cycle with mem_ack=0; clears on ack or on leaving WAIT.
  - On reaching MAX_WAIT: mem_req<=0, timeout_err<=1, go ERR.
- ERR:
  - Outputs idle; timeout_err sticky.
  - Exit only via redirect_valid: clears timeout_err, pc_out<=redirect_pc, go IDLE.
- Redirect (highest priority, any state):
  - Always sets pc_out<=redirect_pc.
  - IDLE/HOLD: inst_valid<=0 (flush, even if inst_ready=1 same cycle); if run=1 issue request at redirect_pc next cycle, else IDLE.
  - WAIT, no ack this cycle: the in-flight request is not aborted (mem_req/mem_addr unchanged). squash<=1. On the later ack the data is discarded, pc_out is not incremented, squash clears, and a new request for pc_out issues next cycle if run=1 (HOLD skipped).
  - WAIT, ack same cycle: data discarded, pc_out=redirect_pc, re-request next cycle if run=1.
  - Multiple redirects before the ack: last one wins.
- run falling during WAIT does not cancel the request; the word is delivered, then the block idles.
- mem_ack outside WAIT is ignored.

Decomposition:
- Package pc_ctrl_pkg: state enum (IDLE, WAIT, HOLD, ERR), default constants STEP, RESET_PC, MAX_WAIT.
- One sub-module, pc_ctrl_wdog: parameterised saturating wait counter with clear/enable inputs and an expired output.
- FSM, PC arithmetic and output buffer stay in pc_fetch_ctrl.

Test Plan:
- Reset, run=1, memory acks 1 cycle after each req, inst_ready=1 -> mem_addr sequence 0,4,8,12; inst_pc matches; inst_data equals the memory contents.
- pc_out=0xFC, fetch completes -> pc_out wraps to 0x00, next mem_addr=0x00.
- inst_ready=0 for 5 cycles in HOLD -> inst_valid, inst_data and inst_pc stable; no new mem_req until the handshake.
- redirect_pc=0x40 pulsed in WAIT, ack 3 cycles later -> that word is never presented on inst_valid; next mem_addr=0x40; pc_out=0x44 after its ack.
- No mem_ack for 15 WAIT cycles -> timeout_err=1, mem_req=0; redirect_pc=0x10 -> timeout_err=0, fetch resumes at 0x10.
- rst_n pulsed low mid-WAIT (asynchronously) -> mem_req drops immediately, pc_out=RESET_PC, inst_valid=0.
